// File: rtl/cdb_arbiter_if.sv
// Bundle of the functional-unit result ports and the common data bus toward the ROB.
// The slave modport is the arbiter's view; master is the FU/ROB side that drives results.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif

interface cdb_arbiter_if #(
    parameter int NUM_FU = 4
);
    logic [NUM_FU-1:0]                        fu_valid;
    logic [NUM_FU-1:0][`ROB_TAG_LEN-1:0]      fu_rob_tag;
    logic [NUM_FU-1:0][`XLEN-1:0]             fu_data;
    logic [NUM_FU-1:0][`XLEN-1:0]             fu_target_pc;
    logic [NUM_FU-1:0]                        fu_mispredict;
    logic [NUM_FU-1:0]                        fu_ready;
    logic                                     cdb_valid;
    logic [`ROB_TAG_LEN-1:0]                  cdb_rob_tag;
    logic [`XLEN-1:0]                         cdb_data;
    logic [`XLEN-1:0]                         cdb_target_pc;
    logic                                     cdb_mispredict;

    modport master (
        output fu_valid, fu_rob_tag, fu_data, fu_target_pc, fu_mispredict,
        input  fu_ready, cdb_valid, cdb_rob_tag, cdb_data, cdb_target_pc, cdb_mispredict
    );

    modport slave (
        input  fu_valid, fu_rob_tag, fu_data, fu_target_pc, fu_mispredict,
        output fu_ready, cdb_valid, cdb_rob_tag, cdb_data, cdb_target_pc, cdb_mispredict
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Per-FU result FIFOs feeding a round-robin arbiter that drives one registered CDB
// write per cycle into the reorder buffer; reset or ROB flush squashes everything.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif

module cdb_arbiter #(
    parameter int NUM_FU     = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    cdb_arbiter_if.slave  bus
);
    localparam int FU_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [`ROB_TAG_LEN-1:0] rob_tag;
        logic [`XLEN-1:0]        data;
        logic [`XLEN-1:0]        target_pc;
        logic                    mispredict;
    } entry_t;

    logic              squash;
    logic [NUM_FU-1:0] req;
    logic [NUM_FU-1:0] ready;
    logic [NUM_FU-1:0] push;
    logic [NUM_FU-1:0] pop;
    entry_t            head [NUM_FU];

    logic [FU_W-1:0]   rr_ptr_reg;
    logic [FU_W-1:0]   rr_ptr_next;
    logic [FU_W-1:0]   winner;
    logic              grant_any;
    int                scan_idx;

    logic              cdb_valid_reg;
    entry_t            cdb_reg;

    assign squash = reset | flush;

    generate
        for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_fifo
            entry_t            mem [FIFO_DEPTH];
            logic [PTR_W-1:0]  wr_ptr_reg;
            logic [PTR_W-1:0]  rd_ptr_reg;
            logic [CNT_W-1:0]  count_reg;

            // Ready and request come from registered counts only, so a full FIFO
            // refuses a push even in the cycle its head is being granted.
            assign ready[gi] = (count_reg < CNT_W'(FIFO_DEPTH));
            assign req[gi]   = (count_reg != '0);
            assign push[gi]  = bus.fu_valid[gi] & ready[gi];
            assign pop[gi]   = grant_any && (winner == FU_W'(gi));
            assign head[gi]  = mem[rd_ptr_reg];

            always_ff @(posedge clk) begin
                if (push[gi]) begin
                    mem[wr_ptr_reg] <= {bus.fu_rob_tag[gi], bus.fu_data[gi],
                                        bus.fu_target_pc[gi], bus.fu_mispredict[gi]};
                end
            end

            always_ff @(posedge clk) begin
                if (squash) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (push[gi]) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                    if (pop[gi])  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
                    case ({push[gi], pop[gi]})
                        2'b10:   count_reg <= count_reg + CNT_W'(1);
                        2'b01:   count_reg <= count_reg - CNT_W'(1);
                        default: count_reg <= count_reg;
                    endcase
                end
            end
        end
    endgenerate

    // Scan requests starting at rr_ptr and wrapping; first hit wins.
    always_comb begin
        grant_any = 1'b0;
        winner    = '0;
        scan_idx  = 0;
        for (int k = 0; k < NUM_FU; k++) begin
            scan_idx = int'(rr_ptr_reg) + k;
            if (scan_idx >= NUM_FU) scan_idx = scan_idx - NUM_FU;
            if (!grant_any && req[FU_W'(scan_idx)]) begin
                grant_any = 1'b1;
                winner    = FU_W'(scan_idx);
            end
        end
    end

    assign rr_ptr_next = (winner == FU_W'(NUM_FU - 1)) ? '0 : winner + FU_W'(1);

    // Payload registers hold their last value when nothing is granted.
    always_ff @(posedge clk) begin
        if (squash) begin
            cdb_valid_reg <= 1'b0;
            cdb_reg       <= '0;
            rr_ptr_reg    <= '0;
        end else if (grant_any) begin
            cdb_valid_reg <= 1'b1;
            cdb_reg       <= head[winner];
            rr_ptr_reg    <= rr_ptr_next;
        end else begin
            cdb_valid_reg <= 1'b0;
        end
    end

    assign bus.fu_ready       = ready;
    assign bus.cdb_valid      = cdb_valid_reg;
    assign bus.cdb_rob_tag    = cdb_reg.rob_tag;
    assign bus.cdb_data       = cdb_reg.data;
    assign bus.cdb_target_pc  = cdb_reg.target_pc;
    assign bus.cdb_mispredict = cdb_reg.mispredict;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Cycle vectors for cdb_arbiter: per-cycle ready/valid/tag expectations plus a tag
// scoreboard that checks payload, per-FU order, and that nothing is lost or invented.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif

module tb_cdb_arbiter;
    localparam int NFU    = 4;
    localparam int TAG_W  = `ROB_TAG_LEN;
    localparam int XLEN_W = `XLEN;
    localparam int F_HOLD  = 1;
    localparam int F_DRAIN = 2;
    localparam int F_ZERO  = 4;

    typedef struct {
        logic                         rst;
        logic                         flush;
        logic [NFU-1:0]               valid;
        logic [NFU-1:0][TAG_W-1:0]    tag;
        logic [NFU-1:0][XLEN_W-1:0]   data;
        logic [NFU-1:0][XLEN_W-1:0]   tpc;
        logic [NFU-1:0]               mp;
        logic [NFU-1:0]               exp_ready;
        logic                         exp_valid;
        logic [TAG_W-1:0]             exp_tag;
        logic                         chk_hold;
        logic                         chk_drain;
        logic                         chk_zero;
    } vec_t;

    typedef struct {
        int                fu;
        logic [TAG_W-1:0]  tag;
        logic [XLEN_W-1:0] data;
        logic [XLEN_W-1:0] tpc;
        logic              mp;
    } sb_t;

    logic clk;
    logic reset;
    logic flush;
    int   errors;
    int   checks;
    int   cyc;
    sb_t  sb_q[$];
    vec_t tbl[$];

    cdb_arbiter_if #(.NUM_FU(NFU)) bus ();

    cdb_arbiter #(.NUM_FU(NFU), .FIFO_DEPTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rst, input logic fl, input logic [NFU-1:0] valid,
                                input int t0, input int t1, input int t2, input int t3,
                                input logic [NFU-1:0] er, input logic ev, input int et,
                                input int flags);
        vec_t v;
        int   t[NFU];
        t = '{t0, t1, t2, t3};
        v.rst   = rst;
        v.flush = fl;
        v.valid = valid;
        for (int i = 0; i < NFU; i++) begin
            v.tag[i]  = TAG_W'(t[i]);
            v.data[i] = XLEN_W'(32'hC0DE_0000 | (32'(t[i]) << 8) | 32'(i));
            v.tpc[i]  = XLEN_W'(32'h0000_8000 + (32'(t[i]) << 2));
        end
        v.mp        = '0;
        v.exp_ready = er;
        v.exp_valid = ev;
        v.exp_tag   = TAG_W'(et);
        v.chk_hold  = (flags & F_HOLD) != 0;
        v.chk_drain = (flags & F_DRAIN) != 0;
        v.chk_zero  = (flags & F_ZERO) != 0;
        return v;
    endfunction

    function automatic vec_t idle(input logic [NFU-1:0] er, input logic ev, input int et,
                                  input int flags);
        return mk(1'b0, 1'b0, '0, 0, 0, 0, 0, er, ev, et, flags);
    endfunction

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h required=%0h", name, cyc, got, req);
        end
    endtask

    task automatic monitor();
        int  hit;
        int  early;
        sb_t rec;
        hit   = -1;
        early = 0;
        if (bus.cdb_valid === 1'b1) begin
            for (int j = 0; j < sb_q.size(); j++)
                if (hit < 0 && sb_q[j].tag == bus.cdb_rob_tag) hit = j;
            checks++;
            if (hit < 0) begin
                errors++;
                $display("FAIL cdb_unexpected cyc=%0d got tag=%0d required=no CDB write",
                         cyc, bus.cdb_rob_tag);
            end else begin
                rec = sb_q[hit];
                for (int j = 0; j < hit; j++)
                    if (sb_q[j].fu == rec.fu) early = early + 1;
                chk("cdb_fu_order", 128'(early), 128'(0));
                chk("cdb_payload", {bus.cdb_data, bus.cdb_target_pc, bus.cdb_mispredict},
                    {rec.data, rec.tpc, rec.mp});
                sb_q.delete(hit);
                $display("cyc=%0d cdb tag=%0d data=%08h tpc=%08h mp=%0b", cyc,
                         bus.cdb_rob_tag, bus.cdb_data, bus.cdb_target_pc, bus.cdb_mispredict);
            end
        end
    endtask

    task automatic step(input vec_t v);
        sb_t rec;
        @(posedge clk);
        #1;
        reset             = v.rst;
        flush             = v.flush;
        bus.fu_valid      = v.valid;
        bus.fu_rob_tag    = v.tag;
        bus.fu_data       = v.data;
        bus.fu_target_pc  = v.tpc;
        bus.fu_mispredict = v.mp;
        if (!v.rst && !v.flush) begin
            for (int i = 0; i < NFU; i++) begin
                if (v.valid[i] && v.exp_ready[i]) begin
                    rec.fu   = i;
                    rec.tag  = v.tag[i];
                    rec.data = v.data[i];
                    rec.tpc  = v.tpc[i];
                    rec.mp   = v.mp[i];
                    sb_q.push_back(rec);
                end
            end
        end
        @(negedge clk);
        cyc++;
        chk("fu_ready", 128'(bus.fu_ready), 128'(v.exp_ready));
        chk("cdb_valid", 128'(bus.cdb_valid), 128'(v.exp_valid));
        if (v.exp_valid || v.chk_hold)
            chk("cdb_rob_tag", 128'(bus.cdb_rob_tag), 128'(v.exp_tag));
        if (v.chk_zero)
            chk("cdb_fields_zero", {bus.cdb_rob_tag, bus.cdb_data, bus.cdb_target_pc,
                                    bus.cdb_mispredict}, 128'(0));
        monitor();
        if (v.chk_drain)
            chk("scoreboard_drained", 128'(sb_q.size()), 128'(0));
        if (v.rst || v.flush)
            sb_q.delete();
    endtask

    initial begin
        vec_t v;
        errors = 0;
        checks = 0;
        cyc    = 0;
        reset  = 1'b1;
        flush  = 1'b0;
        bus.fu_valid      = '0;
        bus.fu_rob_tag    = '0;
        bus.fu_data       = '0;
        bus.fu_target_pc  = '0;
        bus.fu_mispredict = '0;

        // Reset state and single-result latency
        tbl.push_back(mk(1, 0, 4'b0000, 0, 0, 0, 0, 4'b1111, 0, 0, F_HOLD | F_ZERO));
        tbl.push_back(mk(1, 0, 4'b0000, 0, 0, 0, 0, 4'b1111, 0, 0, F_HOLD | F_ZERO));
        v = mk(0, 0, 4'b0001, 3, 0, 0, 0, 4'b1111, 0, 0, 0);
        v.data[0] = 32'hDEAD_BEEF;
        tbl.push_back(v);
        tbl.push_back(idle(4'b1111, 0, 0, 0));
        tbl.push_back(idle(4'b1111, 1, 3, 0));
        tbl.push_back(idle(4'b1111, 0, 3, F_HOLD | F_DRAIN));
        // Four simultaneous results, then rr_ptr back at 0 gives FU0 priority over FU1
        tbl.push_back(mk(1, 0, 4'b0000, 0, 0, 0, 0, 4'b1111, 0, 3, F_HOLD));
        tbl.push_back(mk(0, 0, 4'b1111, 0, 1, 2, 3, 4'b1111, 0, 0, F_ZERO));
        tbl.push_back(idle(4'b1111, 0, 0, 0));
        tbl.push_back(idle(4'b1111, 1, 0, 0));
        tbl.push_back(idle(4'b1111, 1, 1, 0));
        tbl.push_back(idle(4'b1111, 1, 2, 0));
        tbl.push_back(mk(0, 0, 4'b0011, 4, 5, 0, 0, 4'b1111, 1, 3, 0));
        tbl.push_back(idle(4'b1111, 0, 3, F_HOLD));
        tbl.push_back(idle(4'b1111, 1, 4, 0));
        tbl.push_back(idle(4'b1111, 1, 5, 0));
        tbl.push_back(idle(4'b1111, 0, 5, F_HOLD | F_DRAIN));
        // Flush with two entries in FU0 and one in FU3, then a fresh result
        tbl.push_back(mk(1, 0, 4'b0000, 0, 0, 0, 0, 4'b1111, 0, 5, F_HOLD));
        tbl.push_back(mk(0, 0, 4'b0001, 19, 0, 0, 0, 4'b1111, 0, 0, F_ZERO));
        tbl.push_back(idle(4'b1111, 0, 0, 0));
        tbl.push_back(idle(4'b1111, 1, 19, 0));
        tbl.push_back(mk(0, 0, 4'b1011, 20, 30, 0, 23, 4'b1111, 0, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0001, 21, 0, 0, 0, 4'b1111, 0, 0, 0));
        tbl.push_back(mk(0, 1, 4'b0000, 0, 0, 0, 0, 4'b1110, 1, 30, 0));
        tbl.push_back(mk(0, 0, 4'b0001, 25, 0, 0, 0, 4'b1111, 0, 0, F_HOLD | F_ZERO));
        tbl.push_back(idle(4'b1111, 0, 0, 0));
        tbl.push_back(idle(4'b1111, 1, 25, 0));
        tbl.push_back(idle(4'b1111, 0, 25, F_HOLD | F_DRAIN));
        // Mispredict pass-through, then reset with three entries buffered
        v = mk(0, 0, 4'b0100, 0, 0, 7, 0, 4'b1111, 0, 25, F_HOLD);
        v.mp[2]  = 1'b1;
        v.tpc[2] = 32'h0000_0100;
        tbl.push_back(v);
        tbl.push_back(idle(4'b1111, 0, 0, 0));
        tbl.push_back(idle(4'b1111, 1, 7, 0));
        tbl.push_back(mk(0, 0, 4'b0111, 12, 13, 14, 0, 4'b1111, 0, 7, F_HOLD));
        tbl.push_back(mk(1, 0, 4'b0000, 0, 0, 0, 0, 4'b1111, 0, 7, F_HOLD));
        tbl.push_back(idle(4'b1111, 0, 0, F_HOLD | F_ZERO));
        tbl.push_back(idle(4'b1111, 0, 0, 0));
        tbl.push_back(idle(4'b1111, 0, 0, F_HOLD | F_DRAIN));

        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        // Fairness: FU0 and FU2 push every cycle they are ready; held results repeat their tag
        step(mk(1, 0, 4'b0000, 0, 0, 0, 0, 4'b1111, 0, 0, 0));
        step(mk(0, 0, 4'b0101, 8, 0, 16, 0, 4'b1111, 0, 0, F_ZERO));
        step(mk(0, 0, 4'b0101, 9, 0, 17, 0, 4'b1111, 0, 0, 0));
        step(mk(0, 0, 4'b0101, 10, 0, 18, 0, 4'b1011, 1, 8, 0));
        step(mk(0, 0, 4'b0101, 11, 0, 18, 0, 4'b1110, 1, 16, 0));
        step(mk(0, 0, 4'b0101, 11, 0, 19, 0, 4'b1011, 1, 9, 0));
        step(mk(0, 0, 4'b0100, 0, 0, 19, 0, 4'b1110, 1, 17, 0));
        step(idle(4'b1011, 1, 10, 0));
        step(idle(4'b1111, 1, 18, 0));
        step(idle(4'b1111, 1, 11, 0));
        step(idle(4'b1111, 1, 19, 0));
        step(idle(4'b1111, 0, 19, F_HOLD | F_DRAIN));

        // Backpressure: FU1 held valid four cycles, FIFO fills after two accepted pushes
        step(mk(1, 0, 4'b0000, 0, 0, 0, 0, 4'b1111, 0, 0, 0));
        step(mk(0, 0, 4'b0011, 1, 4, 0, 0, 4'b1111, 0, 0, F_ZERO));
        step(mk(0, 0, 4'b0011, 2, 5, 0, 0, 4'b1111, 0, 0, 0));
        step(mk(0, 0, 4'b0010, 0, 6, 0, 0, 4'b1101, 1, 1, 0));
        step(mk(0, 0, 4'b0010, 0, 6, 0, 0, 4'b1111, 1, 4, 0));
        step(idle(4'b1101, 1, 2, 0));
        step(idle(4'b1111, 1, 5, 0));
        step(idle(4'b1111, 1, 6, 0));
        step(idle(4'b1111, 0, 6, F_HOLD | F_DRAIN));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
